muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; all datapaths scale with it, and the values below assume 32.
REQ-002 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port div_start  input  1  signed divide request.
REQ-005 SHALL have port divu_start  input  1  unsigned divide request.
REQ-006 SHALL have port mul_start  input  1  signed multiply request.
REQ-007 SHALL have port mulu_start  input  1  unsigned multiply request.
REQ-008 SHALL have port a  input  WIDTH  dividend / multiplicand (rs).
REQ-009 SHALL have port b  input  WIDTH  divisor / multiplier (rt).
REQ-010 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-011 SHALL have port hi  output  WIDTH  remainder (div) or product upper half (mul).
REQ-012 SHALL have port lo  output  WIDTH  quotient (div) or product lower half (mul).

Function
REQ-013 SHALL implement three states: IDLE, CALC, FIX.
REQ-014 SHALL accept a start only in IDLE; start pulses in CALC/FIX are ignored with no side effect.
REQ-015 SHALL resolve simultaneous starts by priority div > divu > mul > mulu; the lower-priority requests are dropped.
REQ-016 SHALL, on the accepting edge: latch a, b, op and sign flags; load an iteration counter with WIDTH; set busy=1; go IDLE->CALC.
REQ-017 SHALL ignore changes on a/b after acceptance.
REQ-018 SHALL operate on magnitudes for signed ops (two's-complement negate if negative); 0x80000000 has magnitude 2^31.
REQ-019 SHALL, per CALC cycle for divide: one restoring step on a 2*WIDTH shift register (shift left, trial subtract divisor, keep if non-negative, set quotient bit).
REQ-020 SHALL, per CALC cycle for multiply: one shift-add step (add multiplicand to upper half if multiplier LSB=1, shift right).
REQ-021 SHALL decrement the counter each CALC cycle and go CALC->FIX after WIDTH cycles.
REQ-022 SHALL, in FIX (one cycle), apply sign correction: signed quotient negated if sign(a)!=sign(b); signed remainder takes sign of a; signed product (2*WIDTH) negated if signs differ.
REQ-023 SHALL write hi/lo and clear busy on the FIX->IDLE edge; total busy = WIDTH+1 = 33 cycles.
REQ-024 SHALL hold the previous hi/lo unchanged until that edge; no intermediate values are visible.
REQ-025 SHALL, for divide by zero (div or divu), take the full latency and produce lo=0xFFFFFFFF, hi=a.
REQ-026 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000, hi=0.
REQ-027 SHALL accept a new start in the first IDLE cycle after busy falls (back-to-back with one idle cycle).

Reset
REQ-028 SHALL, while rst=1 at an edge: state=IDLE, busy=0, hi=0, lo=0, counter=0; starts in the same cycle are ignored.
REQ-029 SHALL let reset mid-operation abort the operation without any hi/lo update other than clearing to 0.

Verification
REQ-030 SHALL cover: divu a=100, b=7 -> busy high 33 cycles, then lo=0x0000000E, hi=0x00000002.
REQ-031 SHALL cover: div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 SHALL cover: mul a=0xFFFFFFFF, b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; mulu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-033 SHALL cover: div a=5, b=0 -> lo=0xFFFFFFFF, hi=5; div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 SHALL cover: div_start+mul_start in the same cycle with a=20, b=6 -> lo=3, hi=2; mulu_start pulsed during busy -> ignored, result unchanged.
REQ-035 SHALL cover: rst on the 10th busy cycle -> next edge busy=0, hi=lo=0; a divu started the following cycle completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one restoring-divide or shift-add step per cycle,
// with sign fix-up in a single cycle before the result reaches hi/lo.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_start,
   input  logic             divu_start,
   input  logic             mul_start,
   input  logic             mulu_start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_raw;
   logic               is_div, neg_main, neg_rem, div_zero;

   logic               any_start, op_div, op_signed, sign_a, sign_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   res_hi, res_lo;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return ~x + 1'b1;
   endfunction

   // Restoring step; the shifted partial remainder needs WIDTH+1 bits.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0]   d);
      logic [WIDTH:0] trial;
      logic [WIDTH:0] diff;
      trial = {r[2*WIDTH-1:WIDTH-1]};
      diff  = trial - {1'b0, d};
      if (trial >= {1'b0, d})
         return {diff[WIDTH-1:0], r[WIDTH-2:0], 1'b1};
      else
         return {r[2*WIDTH-2:0], 1'b0};
   endfunction

   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, r[2*WIDTH-1:WIDTH]} + (r[0] ? {1'b0, m} : '0);
      return {sum, r[WIDTH-1:1]};
   endfunction

   assign any_start = div_start | divu_start | mul_start | mulu_start;
   assign op_div    = div_start | divu_start;
   assign op_signed = div_start | (~divu_start & mul_start);
   assign sign_a    = op_signed & a[WIDTH-1];
   assign sign_b    = op_signed & b[WIDTH-1];
   assign mag_a     = sign_a ? negate(a) : a;
   assign mag_b     = sign_b ? negate(b) : b;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_start) state_next = CALC;
         CALC:    if (count == CW'(1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      prod   = neg_main ? (~acc + 1'b1) : acc;
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (is_div) begin
         if (div_zero) begin
            res_hi = a_raw;
            res_lo = '1;
         end else begin
            res_hi = neg_rem  ? negate(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
            res_lo = neg_main ? negate(acc[WIDTH-1:0])       : acc[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         count <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: if (any_start) begin
               busy  <= 1'b1;
               count <= CW'(WIDTH);
            end
            CALC: count <= count - 1'b1;
            FIX: begin
               busy <= 1'b0;
               hi   <= res_hi;
               lo   <= res_lo;
            end
            default: ;
         endcase
      end
   end

   // Operand/accumulator registers carry no reset; they are reloaded on every accept.
   always_ff @(posedge clk) begin
      if (state == IDLE && any_start && !rst) begin
         acc      <= op_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
         opnd     <= op_div ? mag_b : mag_a;
         a_raw    <= a;
         is_div   <= op_div;
         neg_main <= sign_a ^ sign_b;
         neg_rem  <= sign_a;
         div_zero <= (b == '0);
      end else if (state == CALC) begin
         acc <= is_div ? div_step(acc, opnd) : mul_step(acc, opnd);
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed vectors checked with immediate assertions.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        div_start = 1'b0, divu_start = 1'b0, mul_start = 1'b0, mulu_start = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        busy;
   logic [31:0] hi, lo;

   int vectors = 0;
   int fails   = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .div_start(div_start), .divu_start(divu_start),
      .mul_start(mul_start), .mulu_start(mulu_start),
      .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // starts = {div, divu, mul, mulu}; called on a negedge with the unit idle.
   task automatic run_op(input string tag, input logic [3:0] starts,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int pulse_at);
      logic [31:0] prev_hi, prev_lo;
      logic        held;
      int          n;
      prev_hi = hi;
      prev_lo = lo;
      held    = 1'b1;
      n       = 0;
      a = av; b = bv;
      {div_start, divu_start, mul_start, mulu_start} = starts;
      @(negedge clk);
      {div_start, divu_start, mul_start, mulu_start} = 4'b0000;
      a = ~av; b = bv ^ 32'h5A5A_1234;
      while (busy && n < 100) begin
         if (hi !== prev_hi || lo !== prev_lo) held = 1'b0;
         mulu_start = (n == pulse_at);
         n++;
         @(negedge clk);
      end
      mulu_start = 1'b0;
      check({tag, " busy_cycles"}, 32'(n), 32'd33);
      check({tag, " held"}, {31'b0, held}, 32'd1);
      check({tag, " hi"}, hi, exp_hi);
      check({tag, " lo"}, lo, exp_lo);
   endtask

   initial begin
      int n;
      div_start = 1'b1;
      a = 32'd9; b = 32'd3;
      repeat (2) @(negedge clk);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset hi", hi, 32'd0);
      check("reset lo", lo, 32'd0);
      rst = 1'b0;
      div_start = 1'b0;
      @(negedge clk);
      check("start under reset ignored", {31'b0, busy}, 32'd0);

      run_op("divu 100/7",   4'b0100, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E, -1);
      run_op("div -7/2",     4'b1000, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, -1);
      run_op("div 7/-2",     4'b1000, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, -1);
      run_op("divu big/2",   4'b0100, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, -1);
      run_op("mul -1*2",     4'b0010, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, -1);
      run_op("mulu ff*2",    4'b0001, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, -1);
      run_op("mul min*min",  4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, -1);
      run_op("div 5/0",      4'b1000, 32'd5,        32'd0,        32'h0000_0005, 32'hFFFF_FFFF, -1);
      run_op("div -7/0",     4'b1000, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, -1);
      run_op("divu ff/0",    4'b0100, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      run_op("div min/-1",   4'b1000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, -1);
      run_op("div+mul 20/6", 4'b1010, 32'd20,       32'd6,        32'h0000_0002, 32'h0000_0003, 5);

      a = 32'd100; b = 32'd7;
      divu_start = 1'b1;
      @(negedge clk);
      divu_start = 1'b0;
      n = 1;
      while (busy && n < 10) begin
         n++;
         @(negedge clk);
      end
      check("busy before abort", {31'b0, busy}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", {31'b0, busy}, 32'd0);
      check("abort hi", hi, 32'd0);
      check("abort lo", lo, 32'd0);
      run_op("divu after abort", 4'b0100, 32'd1000, 32'd3, 32'h0000_0001, 32'h0000_014D, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
